// File: rtl/dog_pkg.sv
// Shared constants and event types for the dog-fight input path.
// btn_evt_t is also consumed by the game FSM.
package dog_pkg;

  localparam int DEF_NUM_CH         = 8;
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_REPEAT_DELAY   = 24;
  localparam int DEF_REPEAT_PERIOD  = 6;

  typedef struct packed {
    logic press;
    logic rel;
    logic rpt;
  } btn_evt_t;

  typedef enum logic {
    RPT_IDLE,
    RPT_HOLD
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dog_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-based debounce and the
// auto-repeat state machine. All event outputs are registered one-cycle pulses.
module dog_debounce_ch
  import dog_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     btn_i,
  input  logic     repeat_en_i,
  output logic     level_o,
  output btn_evt_t evt_o
);

  localparam int DCNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RCNT_W-1:0] RCNT_FIRST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_NEXT  = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1_q, sync2_q;
  logic              stable_q, stable_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  rpt_state_e        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              first_done_q, first_done_d;
  btn_evt_t          evt_q, evt_d;

  always_comb begin
    stable_d     = stable_q;
    dcnt_d       = dcnt_q;
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    first_done_d = first_done_q;
    evt_d        = '0;

    // Any sample agreeing with the stable level restarts the debounce window.
    if (sync2_q == stable_q) begin
      dcnt_d = '0;
    end else if (tick) begin
      if (dcnt_q == DCNT_LAST) begin
        stable_d  = sync2_q;
        dcnt_d    = '0;
        evt_d.press = sync2_q;
        evt_d.rel   = ~sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    case (state_q)
      RPT_IDLE: begin
        if (evt_d.press && repeat_en_i) begin
          state_d      = RPT_HOLD;
          rcnt_d       = '0;
          first_done_d = 1'b0;
        end
      end
      RPT_HOLD: begin
        if (!repeat_en_i || evt_d.rel) begin
          state_d = RPT_IDLE;
        end else if (tick) begin
          if (rcnt_q == (first_done_q ? RCNT_NEXT : RCNT_FIRST)) begin
            evt_d.rpt    = 1'b1;
            rcnt_d       = '0;
            first_done_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: state_d = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      dcnt_q       <= '0;
      state_q      <= RPT_IDLE;
      rcnt_q       <= '0;
      first_done_q <= 1'b0;
      evt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      dcnt_q       <= dcnt_d;
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      first_done_q <= first_done_d;
      evt_q        <= evt_d;
    end
  end

  assign level_o = stable_q;
  assign evt_o   = evt_q;

endmodule

// File: rtl/dog_input_conditioner.sv
// Multi-channel button conditioner feeding the dog-fight game logic:
// NUM_CH independent channels plus a registered any-event strobe.
module dog_input_conditioner
  import dog_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] btn_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic              any_event
);

  btn_evt_t evt [NUM_CH];
  logic     any_event_q, any_event_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dog_debounce_ch #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .btn_i      (btn_in[i]),
      .repeat_en_i(repeat_en[i]),
      .level_o    (level_out[i]),
      .evt_o      (evt[i])
    );
    assign press_pulse[i]   = evt[i].press;
    assign release_pulse[i] = evt[i].rel;
    assign repeat_pulse[i]  = evt[i].rpt;
  end

  // Collapses every pulse of this cycle into a single strobe one cycle later.
  always_comb begin
    any_event_d = |{press_pulse, release_pulse, repeat_pulse};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= any_event_d;
    end
  end

  assign any_event = any_event_q;

endmodule

// File: doc/dog_input_conditioner.md
# dog_input_conditioner

Parametrised multi-channel button conditioner between the raw `ui_in` player inputs and the dog-fight game logic. Each channel is synchronised, debounced, edge-detected and, when enabled, auto-repeated while held. All per-channel events are single-cycle registered pulses, with a global any-event strobe. It generalises the previous fixed 8-button sampling to NUM_CH channels, tick-scaled timing and a per-channel repeat mode.

## Interface
- NUM_CH, 8, number of independent button channels (1..16)
- DEBOUNCE_TICKS, 4, consecutive ticks of a changed input required to accept it (>=1)
- REPEAT_DELAY, 24, ticks held before the first repeat pulse (>=1)
- REPEAT_PERIOD, 6, ticks between later repeat pulses (>=1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  timing strobe (prescaler); all tick counts advance only when high
- btn_in  in  NUM_CH  raw asynchronous buttons, active high
- repeat_en  in  NUM_CH  per-channel auto-repeat enable, sampled every cycle
- level_out  out  NUM_CH  debounced stable level
- press_pulse  out  NUM_CH  one-cycle pulse on accepted 0->1
- release_pulse  out  NUM_CH  one-cycle pulse on accepted 1->0
- repeat_pulse  out  NUM_CH  one-cycle auto-repeat pulse
- any_event  out  1  registered OR of all pulse outputs of the current cycle

## Operation
- Reset: all outputs, sync flops, counters = 0; stable level = 0.
- Per channel: 2-flop synchroniser sync1 -> sync2.
- Debounce counter dcnt, width $clog2(DEBOUNCE_TICKS+1):
  - sync2 == stable: dcnt <= 0 (every cycle, independent of tick).
  - sync2 != stable and tick: if dcnt == DEBOUNCE_TICKS-1, then stable <= sync2, dcnt <= 0, and press or release pulse <= 1. Otherwise dcnt++.
  - sync2 != stable and !tick: hold.
- A single matching sample restarts debounce, so bounces shorter than DEBOUNCE_TICKS ticks are ignored entirely.
- Repeat counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Two states per channel:
  - IDLE: entered on reset, release, or repeat_en low.
  - HOLD: entered on the press edge with rcnt <= 0.
  - In HOLD, each tick rcnt++. On reaching REPEAT_DELAY-1 (first) or REPEAT_PERIOD-1 (later), repeat_pulse <= 1, rcnt <= 0, and a first-done flag is set.
- repeat_en dropping in HOLD returns the channel to IDLE without a pulse. Raising it while held does not start repeating until the next press.
- A press pulse is never coincident with a repeat pulse on the same channel.
- Pulse outputs default to 0 every cycle unless set as above.

## Timing
- With tick held at 1, a btn_in change sampled at edge 1 (sync1) reaches sync2 at edge 2. level_out and the press/release pulse update at edge DEBOUNCE_TICKS+2. any_event follows one cycle later.
- A pulse is high for exactly one clk cycle regardless of tick.
- Repeat: with tick=1, the first repeat_pulse comes REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle, and any_event is a single pulse.
- Reset asserted mid-operation clears everything immediately, with no pulse. A button still held after reset release produces a fresh press after the debounce latency.

## Structure
- Shared package `dog_pkg`: default debounce/repeat constants and a `btn_evt_t` struct {press, release, repeat}, also used by the game FSM.
- Sub-module `dog_debounce_ch` holds one channel (sync, debounce, repeat FSM). The top generates NUM_CH instances and the any_event OR register.

## Test plan
- Clean press, D=4, tick=1: btn_in[0] 0->1 held -> level_out[0]=1 and a single press_pulse[0] at edge 6; no other pulses.
- Bounce: btn_in[2] toggled 1,0,1,0 with 2-cycle periods, then steady 1 -> one press_pulse only, 6 cycles after the final rise; no release.
- Tick scaling: tick every 4th cycle, D=4 -> level change 16±4 cycles after sync2; pulse still 1 cycle wide.
- Repeat: repeat_en[1]=1, held 60 cycles, tick=1 -> repeat pulses 24, 30, 36, 42, 48, 54 cycles after the press; release pulse on drop; none with repeat_en=0.
- Simultaneous: all 8 channels pressed together -> 8 press pulses same cycle, one any_event pulse the next cycle.
- Reset mid-hold: rst pulsed at repeat count 10 -> all outputs 0, no release pulse; press_pulse again 6 cycles after rst deasserts.
